if_fetch_stage: RTL and testbench

- Instruction-fetch stage. Owns the 7-bit word-addressed PC, selects the next PC from the decode-stage redirect sources, and drives a synchronous-read instruction memory.
- Presents the fetched instruction and PC+1 to the IF/ID pipeline register, which sits directly downstream.
- Provides a one-cycle fill state after reset, a HALT state, and a saturating fetch counter for bring-up.

---
 rtl/if_fetch_stage_if.sv | 8 +
 rtl/if_fetch_stage.sv | 100 ++++++++++
 tb/tb_if_fetch_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous-read memory (slave).
interface if_fetch_stage_if;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: 7-bit PC, next-PC selection from decode redirects,
// FILL/RUN/HALT control and a saturating fetch counter.
module if_fetch_stage #(
    parameter logic [6:0]  RESET_PC  = 7'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 StallF,
    input  logic [1:0]           PCSrcD,
    input  logic [6:0]           PCBranchD,
    input  logic [6:0]           PCJumpD,
    input  logic [6:0]           PCJrD,
    if_fetch_stage_if.master     imem,
    output logic [31:0]          ins,
    output logic [6:0]           PC_plus1F,
    output logic                 insValidF,
    output logic                 halted,
    output logic [CNT_W-1:0]     fetch_cnt
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         pc_q, pc_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic               halt_word;
    logic               advance;

    // The only rdata-to-address path: the HALT decision in RUN.
    assign halt_word = (imem.imem_rdata == HALT_WORD);
    assign PC_plus1F = pc_q + 7'd1;
    assign imem.imem_addr = pc_d;
    assign fetch_cnt = fetch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        advance = 1'b0;
        unique case (state_q)
            S_FILL: state_d = S_RUN;
            S_RUN: begin
                if (!StallF) begin
                    advance = 1'b1;
                    unique case (PCSrcD)
                        2'b00: begin
                            if (halt_word) begin
                                state_d = S_HALT;
                                advance = 1'b0;
                            end else begin
                                pc_d = PC_plus1F;
                            end
                        end
                        2'b01: pc_d = PCBranchD;
                        2'b10: pc_d = PCJumpD;
                        2'b11: pc_d = PCJrD;
                    endcase
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FILL;
        endcase
        fetch_cnt_d = fetch_cnt_q;
        if (advance && (fetch_cnt_q != {CNT_W{1'b1}})) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        ins       = 32'd0;
        insValidF = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                insValidF = 1'b1;
                ins       = halt_word ? 32'd0 : imem.imem_rdata;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stimulus, a PC-level behavioural model
// checked every cycle, plus literal expectations at key points.
module tb_if_fetch_stage;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0;
    logic [1:0]  PCSrcD = 2'b00;
    logic [6:0]  PCBranchD = '0, PCJumpD = '0, PCJrD = '0;

    logic [31:0] ins, ins4;
    logic [6:0]  pc1, pc1_4;
    logic        valid, valid4, halted, halted4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    logic [31:0] mem [0:127];
    int total = 0;
    int bad = 0;

    if_fetch_stage_if bus ();
    if_fetch_stage_if bus4 ();

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .PCJrD(PCJrD),
        .imem(bus.master), .ins(ins), .PC_plus1F(pc1), .insValidF(valid),
        .halted(halted), .fetch_cnt(cnt)
    );

    if_fetch_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .PCJrD(PCJrD),
        .imem(bus4.master), .ins(ins4), .PC_plus1F(pc1_4), .insValidF(valid4),
        .halted(halted4), .fetch_cnt(cnt4)
    );

    always @(posedge clk) bus.imem_rdata  <= mem[bus.imem_addr];
    always @(posedge clk) bus4.imem_rdata <= mem[bus4.imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting for first fetch, 1 = running, 2 = halted.
    int m_pc = 0;
    int m_phase = 0;
    int m_cnt = 0;

    function automatic int exp_next();
        if (m_phase != 1 || StallF) return m_pc;
        case (PCSrcD)
            2'b00:   return (mem[m_pc] == HALT) ? m_pc : (m_pc + 1) % 128;
            2'b01:   return int'(PCBranchD);
            2'b10:   return int'(PCJumpD);
            default: return int'(PCJrD);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int nxt;
        if (!rst_n) begin
            m_pc = 0; m_phase = 0; m_cnt = 0;
        end else begin
            nxt = exp_next();
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1 && !StallF) begin
                if (PCSrcD == 2'b00 && mem[m_pc] == HALT) m_phase = 2;
                else m_cnt++;
            end
            m_pc = nxt;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_ins;
        e_ins = (m_phase == 1 && mem[m_pc] != HALT) ? mem[m_pc] : 32'd0;
        chk("m_ins", ins, e_ins);
        chk("m_ins4", ins4, e_ins);
        chk("m_valid", {31'd0, valid}, {31'd0, m_phase == 1});
        chk("m_valid4", {31'd0, valid4}, {31'd0, m_phase == 1});
        chk("m_halted", {31'd0, halted}, {31'd0, m_phase == 2});
        chk("m_halted4", {31'd0, halted4}, {31'd0, m_phase == 2});
        chk("m_pc1", pc1, (m_pc + 1) % 128);
        chk("m_pc1_4", pc1_4, (m_pc + 1) % 128);
        chk("m_addr", bus.imem_addr, exp_next());
        chk("m_addr4", bus4.imem_addr, exp_next());
        chk("m_cnt", cnt, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("m_cnt4", cnt4, (m_cnt > 15) ? 15 : m_cnt);
    end

    task automatic drive(input logic s, input logic [1:0] src,
                         input logic [6:0] br, input logic [6:0] j, input logic [6:0] jr);
        #1;
        StallF = s; PCSrcD = src; PCBranchD = br; PCJumpD = j; PCJrD = jr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        $display("cyc t=%0t pc1=%0d ins=%h valid=%b halted=%b cnt=%0d cnt4=%0d",
                 $time, pc1, ins, valid, halted, cnt, cnt4);
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (m_pc != target && n < 300) begin
            step();
            n++;
        end
        chk("run_to_pc1", pc1, (target + 1) % 128);
    endtask

    task automatic do_reset();
        drive(0, 2'b00, 7'd0, 7'd0, 7'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_ins", ins, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc1", pc1, 32'd1);
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_cnt4", cnt4, 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("fill_valid", {31'd0, valid}, 32'd0);
        chk("fill_addr", bus.imem_addr, 32'd0);
    endtask

    initial begin
        int tgt;
        for (int k = 0; k < 128; k++) mem[k] = 32'h100 + k;
        do_reset();
        release_reset();

        // First fetches after reset
        for (int k = 0; k < 4; k++) begin
            step();
            chk("seq_ins", ins, 32'h100 + k);
            chk("seq_pc1", pc1, k + 1);
            chk("seq_cnt", cnt, k);
        end
        step();
        step();
        chk("pc5_ins", ins, 32'h105);

        // Stall at PC=5 for three cycles, then a stalled branch request
        drive(1, 2'b00, 7'd0, 7'd0, 7'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) drive(1, 2'b01, 7'd40, 7'd0, 7'd0);
            step();
            chk("stall_ins", ins, 32'h105);
            chk("stall_pc1", pc1, 32'd6);
            chk("stall_cnt", cnt, 32'd5);
        end
        drive(0, 2'b00, 7'd0, 7'd0, 7'd0);
        step();
        chk("post_stall_pc1", pc1, 32'd7);

        // Redirects from PC=10
        run_to(10);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 2'(k), 7'd40, 7'd80, 7'd120);
            step();
            tgt = (k == 1) ? 40 : (k == 2) ? 80 : 120;
            chk("redir_ins", ins, 32'h100 + tgt);
            chk("redir_pc1", pc1, tgt + 1);
            drive(0, 2'b11, 7'd0, 7'd0, 7'd10);
            step();
            chk("back_pc1", pc1, 32'd11);
        end

        // Wrap 127 -> 0
        drive(0, 2'b00, 7'd0, 7'd0, 7'd0);
        run_to(127);
        chk("wrap_pc1_127", pc1, 32'd0);
        chk("wrap_ins_127", ins, 32'h17F);
        step();
        chk("wrap_ins", ins, 32'h100);
        chk("wrap_pc1", pc1, 32'd1);
        chk("sat_cnt4_run", cnt4, 32'hF);

        // HALT word reached sequentially, first with a stall on top
        do_reset();
        mem[20] = HALT;
        release_reset();
        run_to(20);
        chk("halt_cyc_ins", ins, 32'd0);
        chk("halt_cyc_valid", {31'd0, valid}, 32'd1);
        drive(1, 2'b00, 7'd0, 7'd0, 7'd0);
        step();
        chk("halt_stall_halted", {31'd0, halted}, 32'd0);
        chk("halt_stall_pc1", pc1, 32'd21);
        drive(0, 2'b00, 7'd0, 7'd0, 7'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("halted", {31'd0, halted}, 32'd1);
            chk("halted_valid", {31'd0, valid}, 32'd0);
            chk("halted_ins", ins, 32'd0);
            chk("halted_addr", bus.imem_addr, 32'd20);
            chk("halted_cnt", cnt, 32'd20);
            chk("halted_cnt4", cnt4, 32'hF);
        end

        // Wrong-path HALT word: jump taken instead
        do_reset();
        release_reset();
        run_to(20);
        drive(0, 2'b10, 7'd0, 7'd50, 7'd0);
        step();
        chk("wp_halted", {31'd0, halted}, 32'd0);
        chk("wp_ins", ins, 32'h132);
        chk("wp_pc1", pc1, 32'd51);
        chk("wp_cnt", cnt, 32'd21);
        drive(0, 2'b00, 7'd0, 7'd0, 7'd0);
        repeat (3) step();
        chk("wp_after_ins", ins, 32'h135);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
